// File: rtl/ace_snoop_if.sv
// Snoop-side channel bundle of the ACE port: AC request, cache lookup port, CR response and CD data.
// The slave modport is the responder's view; master is the interconnect/cache environment's view.
interface ace_snoop_if #(
    parameter int AddrWidth = 64,
    parameter int DataWidth = 128,
    parameter int LineWidth = 512
);
    logic                 ac_valid_i;
    logic                 ac_ready_o;
    logic [AddrWidth-1:0] ac_addr_i;
    logic [3:0]           ac_snoop_i;

    logic                 lkp_req_o;
    logic                 lkp_gnt_i;
    logic [AddrWidth-1:0] lkp_addr_o;
    logic                 lkp_clean_o;
    logic                 lkp_inval_o;
    logic                 lkp_valid_i;
    logic                 lkp_hit_i;
    logic                 lkp_dirty_i;
    logic                 lkp_shared_i;
    logic [LineWidth-1:0] lkp_data_i;

    logic                 cr_valid_o;
    logic                 cr_ready_i;
    logic [4:0]           cr_resp_o;

    logic                 cd_valid_o;
    logic                 cd_ready_i;
    logic [DataWidth-1:0] cd_data_o;
    logic                 cd_last_o;

    modport slave (
        input  ac_valid_i, ac_addr_i, ac_snoop_i,
        input  lkp_gnt_i, lkp_valid_i, lkp_hit_i, lkp_dirty_i, lkp_shared_i, lkp_data_i,
        input  cr_ready_i, cd_ready_i,
        output ac_ready_o, lkp_req_o, lkp_addr_o, lkp_clean_o, lkp_inval_o,
        output cr_valid_o, cr_resp_o, cd_valid_o, cd_data_o, cd_last_o
    );

    modport master (
        output ac_valid_i, ac_addr_i, ac_snoop_i,
        output lkp_gnt_i, lkp_valid_i, lkp_hit_i, lkp_dirty_i, lkp_shared_i, lkp_data_i,
        output cr_ready_i, cd_ready_i,
        input  ac_ready_o, lkp_req_o, lkp_addr_o, lkp_clean_o, lkp_inval_o,
        input  cr_valid_o, cr_resp_o, cd_valid_o, cd_data_o, cd_last_o
    );
endinterface

// File: rtl/ace_snoop_responder.sv
// ACE snoop responder: one AC snoop at a time, one L1 lookup, then CR and optional CD line burst.
// Define ACE_SNOOP_STATS_EN to add saturating snoop/hit counters (snoop_cnt_o, hit_cnt_o).
//
// state  | meaning
// IDLE   | ready for an AC snoop
// LOOKUP | lookup presented to the cache, waiting for grant
// WAIT   | waiting for the lookup result
// CR     | snoop response presented
// CD     | streaming the latched line, one beat per CD handshake
module ace_snoop_responder #(
    parameter int AddrWidth = 64,
    parameter int DataWidth = 128,
    parameter int LineWidth = 512
) (
    input  logic        clk_i,
    input  logic        rst_i,
    ace_snoop_if.slave  bus
`ifdef ACE_SNOOP_STATS_EN
    ,
    output logic [31:0] snoop_cnt_o,
    output logic [31:0] hit_cnt_o
`endif
);
    localparam int Beats    = LineWidth / DataWidth;
    localparam int BeatW    = (Beats > 1) ? $clog2(Beats) : 1;
    localparam int OffBytes = LineWidth / 8;
    localparam logic [AddrWidth-1:0] AddrMask = ~AddrWidth'(OffBytes - 1);
    localparam logic [BeatW-1:0]     LastBeat = BeatW'(Beats - 1);

    typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_WAIT, S_CR, S_CD} state_t;

    state_t               state, state_d;
    logic [AddrWidth-1:0] addr_q;
    logic [3:0]           snoop_q;
    logic                 clean_q, inval_q;
    logic [4:0]           resp_q;
    logic [LineWidth-1:0] line_q;
    logic [BeatW-1:0]     beat_q;

    logic                 dec_known, dec_clean, dec_inval;
    logic                 hit_dt, hit_pd, hit_is;
    logic [4:0]           resp_hit;

    always_comb begin
        dec_known = 1'b1;
        dec_clean = 1'b0;
        dec_inval = 1'b0;
        case (bus.ac_snoop_i)
            4'b0000: ;
            4'b0001, 4'b0010, 4'b0011, 4'b1000: dec_clean = 1'b1;
            4'b0111, 4'b1001, 4'b1101:          dec_inval = 1'b1;
            default:                            dec_known = 1'b0;
        endcase
    end

    // Hit response; MakeInvalid falls to the default and discards dirty data.
    always_comb begin
        hit_dt = 1'b0;
        hit_pd = 1'b0;
        hit_is = 1'b0;
        case (snoop_q)
            4'b0000: begin hit_dt = 1'b1; hit_is = 1'b1; end
            4'b0001, 4'b0010, 4'b0011: begin
                hit_dt = 1'b1; hit_pd = bus.lkp_dirty_i; hit_is = 1'b1;
            end
            4'b0111: begin hit_dt = 1'b1; hit_pd = bus.lkp_dirty_i; end
            4'b1000: begin
                hit_dt = bus.lkp_dirty_i; hit_pd = bus.lkp_dirty_i; hit_is = 1'b1;
            end
            4'b1001: begin hit_dt = bus.lkp_dirty_i; hit_pd = bus.lkp_dirty_i; end
            default: ;
        endcase
        resp_hit = {~bus.lkp_shared_i, hit_is, hit_pd, 1'b0, hit_dt};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= S_IDLE;
            addr_q  <= '0;
            snoop_q <= '0;
            clean_q <= 1'b0;
            inval_q <= 1'b0;
            resp_q  <= '0;
            line_q  <= '0;
            beat_q  <= '0;
        end else begin
            state <= state_d;
            case (state)
                S_IDLE: if (bus.ac_valid_i) begin
                    addr_q  <= bus.ac_addr_i & AddrMask;
                    snoop_q <= bus.ac_snoop_i;
                    clean_q <= dec_clean;
                    inval_q <= dec_inval;
                    resp_q  <= dec_known ? 5'b00000 : 5'b00010;
                end
                S_WAIT: if (bus.lkp_valid_i) begin
                    resp_q <= bus.lkp_hit_i ? resp_hit : 5'b00000;
                    line_q <= bus.lkp_data_i;
                end
                S_CR: beat_q <= '0;
                S_CD: if (bus.cd_ready_i) beat_q <= beat_q + 1'b1;
                default: ;
            endcase
        end
    end

    // ac_ready is gated by rst_i so it stays low for the whole reset pulse.
    always_comb begin
        state_d         = state;
        bus.ac_ready_o  = 1'b0;
        bus.lkp_req_o   = 1'b0;
        bus.lkp_addr_o  = '0;
        bus.lkp_clean_o = 1'b0;
        bus.lkp_inval_o = 1'b0;
        bus.cr_valid_o  = 1'b0;
        bus.cr_resp_o   = '0;
        bus.cd_valid_o  = 1'b0;
        bus.cd_data_o   = '0;
        bus.cd_last_o   = 1'b0;
        case (state)
            S_IDLE: begin
                bus.ac_ready_o = ~rst_i;
                if (bus.ac_valid_i) state_d = dec_known ? S_LOOKUP : S_CR;
            end
            S_LOOKUP: begin
                bus.lkp_req_o   = 1'b1;
                bus.lkp_addr_o  = addr_q;
                bus.lkp_clean_o = clean_q;
                bus.lkp_inval_o = inval_q;
                if (bus.lkp_gnt_i) state_d = S_WAIT;
            end
            S_WAIT: if (bus.lkp_valid_i) state_d = S_CR;
            S_CR: begin
                bus.cr_valid_o = 1'b1;
                bus.cr_resp_o  = resp_q;
                if (bus.cr_ready_i) state_d = resp_q[0] ? S_CD : S_IDLE;
            end
            S_CD: begin
                bus.cd_valid_o = 1'b1;
                bus.cd_data_o  = line_q[int'(beat_q) * DataWidth +: DataWidth];
                bus.cd_last_o  = (beat_q == LastBeat);
                if (bus.cd_ready_i && beat_q == LastBeat) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef ACE_SNOOP_STATS_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            snoop_cnt_o <= '0;
            hit_cnt_o   <= '0;
        end else begin
            if (state == S_IDLE && bus.ac_valid_i && snoop_cnt_o != '1)
                snoop_cnt_o <= snoop_cnt_o + 1'b1;
            if (state == S_WAIT && bus.lkp_valid_i && bus.lkp_hit_i && hit_cnt_o != '1)
                hit_cnt_o <= hit_cnt_o + 1'b1;
        end
    end
`endif
endmodule
